// File: rtl/vga_pixfmt.sv
// vga_pixfmt: pixel output stage behind the VGA timing generator.
// Pops packed 32-bit words from the pixel FIFO on visible pixels, unpacks
// RGB332 / RGB565 / RGB888 pixels, expands them to RGB888 by MSB
// replication, and drives colour together with DE, syncs and frame end
// through a matching 2-step pipeline. FIFO underruns blank the affected
// word slot, raise a sticky flag and bump a saturating counter.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   en_i                  core enable (low clears pipeline next clock)
//   pclk_en_i             pixel-clock enable
//   mode_i[1:0]           00 RGB332, 01 RGB565, 1x RGB888
//   hpol_i, vpol_i        invert hsync_o / vsync_o when 1
//   clr_i                 clears underflow_o and urun_cnt_o
//   de_i, hsync_i, vsync_i, hend_i, vend_i   timing generator strobes
//   fifo_valid_i, fifo_data_i[31:0]          FIFO head
//   fifo_ready_o          pop strobe (combinational)
//   red_o, green_o, blue_o[7:0]              pixel colour
//   hsync_o, vsync_o, de_o, vend_o           aligned video controls
//   underflow_o, urun_cnt_o[15:0]            underrun status
module vga_pixfmt (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        pclk_en_i,
  input  logic [1:0]  mode_i,
  input  logic        hpol_i,
  input  logic        vpol_i,
  input  logic        clr_i,
  input  logic        de_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        hend_i,
  input  logic        vend_i,
  input  logic        fifo_valid_i,
  input  logic [31:0] fifo_data_i,
  output logic        fifo_ready_o,
  output logic [7:0]  red_o,
  output logic [7:0]  green_o,
  output logic [7:0]  blue_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        vend_o,
  output logic        underflow_o,
  output logic [15:0] urun_cnt_o
);

  function automatic logic [23:0] expand(input logic [1:0] mode, input logic [23:0] px);
    case (mode)
      2'b00:   expand = {px[7:5], px[7:5], px[7:6],
                         px[4:2], px[4:2], px[4:3],
                         {4{px[1:0]}}};
      2'b01:   expand = {px[15:11], px[15:13],
                         px[10:5],  px[10:9],
                         px[4:0],   px[4:2]};
      default: expand = px;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        step;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  idx_q, idx_d;
  logic        bad_q, bad_d;
  logic        uflow_q, uflow_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] word_q;
  logic [1:0]  last;
  logic        slot0, urun, px_bad;
  logic [31:0] src;
  logic [23:0] raw;

  logic [23:0] raw_p1;
  logic [1:0]  mode_p1;
  logic        bad_p1, vld_p1, hs_p1, vs_p1, ve_p1;
  logic [23:0] rgb_p2;
  logic        vld_p2, hs_p2, vs_p2, ve_p2;

  assign step  = en_i && pclk_en_i;
  assign slot0 = (idx_q == 2'd0);
  assign urun  = step && de_i && slot0 && !fifo_valid_i;
  assign fifo_ready_o = step && de_i && slot0 && fifo_valid_i;

  // Slot 0 reads straight from the FIFO head so the pop and the first pixel
  // happen in the same step; later slots read the captured word.
  assign src    = slot0 ? fifo_data_i : word_q;
  assign px_bad = slot0 ? !fifo_valid_i : bad_q;

  always_comb begin
    case (mode_q)
      2'b00:   last = 2'd3;
      2'b01:   last = 2'd1;
      default: last = 2'd0;
    endcase
  end

  always_comb begin
    case (mode_q)
      2'b00:   raw = {16'd0, src[{idx_q, 3'b000} +: 8]};
      2'b01:   raw = {8'd0, src[{idx_q[0], 4'b0000} +: 16]};
      default: raw = src[23:0];
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    idx_d  = idx_q;
    bad_d  = bad_q;
    if (!en_i) begin
      mode_d = mode_i;
      idx_d  = 2'd0;
      bad_d  = 1'b0;
    end else if (pclk_en_i) begin
      if (vend_i) mode_d = mode_i;
      if (de_i && slot0) bad_d = !fifo_valid_i;
      if (hend_i)    idx_d = 2'd0;
      else if (de_i) idx_d = (idx_q == last) ? 2'd0 : idx_q + 2'd1;
    end
  end

  // A coincident underrun beats clr: the new underrun is the first counted.
  always_comb begin
    uflow_d = uflow_q;
    cnt_d   = cnt_q;
    if (urun) begin
      uflow_d = 1'b1;
      cnt_d   = clr_i ? 16'd1 : sat_inc(cnt_q);
    end else if (clr_i) begin
      uflow_d = 1'b0;
      cnt_d   = 16'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q  <= 2'b10;
      idx_q   <= 2'd0;
      bad_q   <= 1'b0;
      uflow_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      uflow_q <= uflow_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_ready_o) word_q <= fifo_data_i;
  end

  // Stage 1: raw pixel with its format, bad flag, DE, syncs, vend
  always_ff @(posedge clk_i) begin
    if (!en_i)     raw_p1 <= '0;
    else if (step) raw_p1 <= raw;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_p1 <= 2'b10;
      bad_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      hs_p1   <= 1'b0;
      vs_p1   <= 1'b0;
      ve_p1   <= 1'b0;
    end else if (!en_i) begin
      mode_p1 <= 2'b00;
      bad_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      hs_p1   <= 1'b0;
      vs_p1   <= 1'b0;
      ve_p1   <= 1'b0;
    end else if (pclk_en_i) begin
      mode_p1 <= mode_q;
      bad_p1  <= px_bad;
      vld_p1  <= de_i;
      hs_p1   <= hsync_i;
      vs_p1   <= vsync_i;
      ve_p1   <= vend_i;
    end
  end

  // Stage 2: expanded colour (blanked outside DE or on underrun), polarised syncs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rgb_p2 <= '0;
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
      ve_p2  <= 1'b0;
    end else if (!en_i) begin
      rgb_p2 <= '0;
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
      ve_p2  <= 1'b0;
    end else if (pclk_en_i) begin
      rgb_p2 <= (vld_p1 && !bad_p1) ? expand(mode_p1, raw_p1) : 24'd0;
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1 ^ hpol_i;
      vs_p2  <= vs_p1 ^ vpol_i;
      ve_p2  <= ve_p1;
    end
  end

  assign red_o       = rgb_p2[23:16];
  assign green_o     = rgb_p2[15:8];
  assign blue_o      = rgb_p2[7:0];
  assign de_o        = vld_p2;
  assign hsync_o     = hs_p2;
  assign vsync_o     = vs_p2;
  assign vend_o      = ve_p2;
  assign underflow_o = uflow_q;
  assign urun_cnt_o  = cnt_q;

endmodule

// File: tb/tb_vga_pixfmt.sv
// Testbench for vga_pixfmt: a frame-level reference model tracks pixel
// position within the line, word consumption and underrun accounting, and
// is compared every cycle; directed tables and sequences add explicit
// expectations for the main formats and corner cases.
module tb_vga_pixfmt;
  logic        clk = 1'b0;
  logic        rst_n, en, pclk_en, hpol, vpol, clr;
  logic        de, hs, vs, hend, vend, fvalid;
  logic [1:0]  mode;
  logic [31:0] fdata;
  logic        fready;
  logic [7:0]  r, g, b;
  logic        hso, vso, deo, vendo, uflow;
  logic [15:0] cnt;

  always #5 clk = ~clk;

  vga_pixfmt dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .pclk_en_i(pclk_en),
    .mode_i(mode), .hpol_i(hpol), .vpol_i(vpol), .clr_i(clr),
    .de_i(de), .hsync_i(hs), .vsync_i(vs), .hend_i(hend), .vend_i(vend),
    .fifo_valid_i(fvalid), .fifo_data_i(fdata), .fifo_ready_o(fready),
    .red_o(r), .green_o(g), .blue_o(b),
    .hsync_o(hso), .vsync_o(vso), .de_o(deo), .vend_o(vendo),
    .underflow_o(uflow), .urun_cnt_o(cnt)
  );

  int errors = 0;
  int checks = 0;
  int pops = 0;
  logic popped;
  logic [31:0] fq[$];

  typedef struct packed {
    logic [23:0] rgb;
    logic c_de, c_hs, c_vs, c_ve;
  } pix_t;

  // reference model state
  int          m_mode, m_pos, m_cnt;
  logic        m_bad, m_flag;
  logic [31:0] m_word;
  pix_t        m_s1, m_s2;

  typedef struct {
    logic de, hend, vend, valid;
    logic [1:0] md;
    logic [31:0] data;
    logic ready;
    logic [23:0] rgb;
    logic deo, veo;
  } vec_t;
  vec_t tv[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_px(input int md, input logic [31:0] w, input int slot);
    int v, rr, gg, bb, ro, go, bo;
    if (md == 0) begin
      v = int'((w >> (8 * slot)) & 32'hFF);
      rr = v / 32; gg = (v / 4) % 8; bb = v % 4;
      ro = rr * 32 + rr * 4 + rr / 2;
      go = gg * 32 + gg * 4 + gg / 2;
      bo = bb * 85;
    end else if (md == 1) begin
      v = int'((w >> (16 * slot)) & 32'hFFFF);
      rr = v / 2048; gg = (v / 32) % 64; bb = v % 32;
      ro = rr * 8 + rr / 4;
      go = gg * 4 + gg / 16;
      bo = bb * 8 + bb / 4;
    end else begin
      ro = int'((w >> 16) & 32'hFF);
      go = int'((w >> 8) & 32'hFF);
      bo = int'(w & 32'hFF);
    end
    return {ro[7:0], go[7:0], bo[7:0]};
  endfunction

  task automatic model_reset();
    m_mode = 2; m_pos = 0; m_cnt = 0; m_bad = 1'b0; m_flag = 1'b0;
    m_word = '0; m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_step(input int slot);
    pix_t n;
    logic ur;
    ur = en && pclk_en && de && (slot == 0) && !fvalid;
    if (ur) begin
      m_flag = 1'b1;
      m_cnt = clr ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
    end else if (clr) begin
      m_flag = 1'b0;
      m_cnt = 0;
    end
    if (!en) begin
      m_s1 = '0; m_s2 = '0; m_pos = 0; m_bad = 1'b0; m_mode = int'(mode);
    end else if (pclk_en) begin
      if (de && slot == 0) begin
        if (fvalid) begin m_word = fdata; m_bad = 1'b0; end
        else m_bad = 1'b1;
      end
      n = '0;
      n.c_de = de; n.c_hs = hs; n.c_vs = vs; n.c_ve = vend;
      if (de && !m_bad) n.rgb = exp_px(m_mode, m_word, slot);
      m_s2 = m_s1;
      m_s2.c_hs = m_s1.c_hs ^ hpol;
      m_s2.c_vs = m_s1.c_vs ^ vpol;
      m_s1 = n;
      if (hend) m_pos = 0;
      else if (de) m_pos++;
      if (vend) m_mode = int'(mode);
    end
  endtask

  // One clock: called at the falling edge with inputs already set.
  task automatic tick();
    int ppw, slot;
    logic exp_pop;
    #1;
    ppw = (m_mode == 0) ? 4 : (m_mode == 1) ? 2 : 1;
    slot = m_pos % ppw;
    exp_pop = en && pclk_en && de && (slot == 0) && fvalid;
    chk("fifo_ready", 64'(fready), 64'(exp_pop));
    popped = fready;
    model_step(slot);
    @(posedge clk);
    #1;
    chk("video_out", 64'({r, g, b, deo, hso, vso, vendo}), 64'(m_s2));
    chk("underrun", 64'({uflow, cnt}), 64'({m_flag, m_cnt[15:0]}));
    if (popped) begin
      pops++;
      if (fq.size() != 0) fdata = fq.pop_front();
      else fdata = $urandom;
    end
    @(negedge clk);
  endtask

  task automatic strobe(input logic d, input logic he, input logic ve);
    de = d; hend = he; vend = ve;
    tick();
    hend = 1'b0; vend = 1'b0;
  endtask

  initial begin
    int p0;
    rst_n = 1'b0; en = 1'b0; pclk_en = 1'b1; hpol = 1'b0; vpol = 1'b0; clr = 1'b0;
    de = 1'b0; hs = 1'b0; vs = 1'b0; hend = 1'b0; vend = 1'b0;
    fvalid = 1'b1; mode = 2'b10; fdata = '0;
    model_reset();

    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h00112233, 1'b1, 24'h000000, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h00445566, 1'b1, 24'h112233, 1'b1, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h00778899, 1'b1, 24'h445566, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 32'h00AABBCC, 1'b1, 24'h778899, 1'b1, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h00000000, 1'b0, 24'hAABBCC, 1'b1, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h00000000, 1'b0, 24'h000000, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'h00000000, 1'b0, 24'h000000, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'hF800001F, 1'b1, 24'h000000, 1'b0, 1'b1};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h12345678, 1'b0, 24'h0000FF, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 32'h12345678, 1'b0, 24'hFF0000, 1'b1, 1'b0};
    tv[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h00000000, 1'b0, 24'h000000, 1'b0, 1'b0};

    #12;
    chk("reset_video", 64'({r, g, b, deo, hso, vso, vendo}), 64'd0);
    chk("reset_underrun", 64'({uflow, cnt}), 64'd0);
    chk("reset_ready", 64'(fready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    strobe(1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0);

    // RGB888 sweep, then RGB565 unpack
    for (int i = 0; i < 11; i++) begin
      de = tv[i].de; hend = tv[i].hend; vend = tv[i].vend;
      fvalid = tv[i].valid; mode = tv[i].md; fdata = tv[i].data;
      tick();
      chk($sformatf("tv%0d_ready", i), 64'(popped), 64'(tv[i].ready));
      chk($sformatf("tv%0d_pix", i), 64'({r, g, b, deo, vendo}),
          64'({tv[i].rgb, tv[i].deo, tv[i].veo}));
    end
    hend = 1'b0; vend = 1'b0;

    // RGB332: 6-pixel line drops the tail of word 2; next line pops fresh
    mode = 2'b00;
    strobe(1'b0, 1'b1, 1'b1);
    fdata = 32'h000000E3;
    fq.push_back(32'h5A5A5A5A);
    fq.push_back(32'h0000001C);
    p0 = pops;
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    chk("rgb332_E3", 64'({r, g, b, deo}), 64'({24'hFF00FF, 1'b1}));
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0);
    chk("rgb332_pops_line", 64'(pops - p0), 64'd2);
    strobe(1'b1, 1'b0, 1'b0);
    chk("rgb332_fresh_pop", 64'(popped), 64'd1);
    chk("rgb332_fresh_word", 64'(pops - p0), 64'd3);
    strobe(1'b0, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b0);

    // Underrun in RGB565, then coincident clr, then plain clr
    mode = 2'b01;
    strobe(1'b0, 1'b1, 1'b1);
    fvalid = 1'b0;
    p0 = pops;
    strobe(1'b1, 1'b0, 1'b0);
    chk("urun_first", 64'({uflow, cnt}), 64'({1'b1, 16'd1}));
    strobe(1'b1, 1'b0, 1'b0);
    chk("urun_black0", 64'({r, g, b, deo}), 64'({24'h0, 1'b1}));
    strobe(1'b0, 1'b1, 1'b0);
    chk("urun_black1", 64'({r, g, b, deo}), 64'({24'h0, 1'b1}));
    strobe(1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    strobe(1'b1, 1'b0, 1'b0);
    clr = 1'b0;
    chk("urun_clr_wins", 64'({uflow, cnt}), 64'({1'b1, 16'd1}));
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0);
    chk("urun_no_pop", 64'(pops - p0), 64'd0);
    pclk_en = 1'b0; clr = 1'b1;
    strobe(1'b0, 1'b0, 1'b0);
    clr = 1'b0; pclk_en = 1'b1;
    chk("urun_cleared", 64'({uflow, cnt}), 64'd0);
    fvalid = 1'b1;

    // hsync polarity with pclk enable every 4th cycle
    hpol = 1'b1;
    for (int i = 0; i < 32; i++) begin
      pclk_en = (i % 4 == 0);
      hs = ((i / 8) % 2 == 1);
      strobe(1'b1, (i % 16 == 12), 1'b0);
    end
    hs = 1'b0; pclk_en = 1'b1;
    strobe(1'b0, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b0);
    chk("hsync_inverted", 64'(hso), 64'd1);
    hpol = 1'b0;

    // mode change mid-line is deferred; en_i low mid-line clears outputs
    p0 = pops;
    mode = 2'b10;
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0, 1'b0);
    chk("mode_deferred_pops", 64'(pops - p0), 64'd2);
    en = 1'b0;
    strobe(1'b1, 1'b0, 1'b0);
    chk("en_low_no_pop", 64'(popped), 64'd0);
    chk("en_low_clear", 64'({r, g, b, deo, hso, vso, vendo}), 64'd0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 99) >= 2);
      pclk_en = ($urandom_range(0, 99) < 70);
      mode = 2'($urandom_range(0, 3));
      de = ($urandom_range(0, 99) < 70);
      hend = ($urandom_range(0, 99) < 12);
      vend = hend && ($urandom_range(0, 99) < 25);
      hs = ($urandom_range(0, 99) < 20);
      vs = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 1) hpol = ~hpol;
      if ($urandom_range(0, 99) < 1) vpol = ~vpol;
      clr = ($urandom_range(0, 99) < 2);
      fvalid = ($urandom_range(0, 99) < 85);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_pixfmt.md
# vga_pixfmt

Pixel output stage placed directly downstream of the VGA timing generator. It consumes the generator's `de`, `hsync`, `vsync`, `hend` and `vend` strobes on each pixel-clock enable. On visible pixels it pops packed 32-bit words from the pixel FIFO, unpacks and expands them to RGB888, and drives them to the DAC/pads with sync and DE delayed to match. It also detects and counts FIFO underruns.

## Interface
- No parameters; data word fixed at 32 bits, colour channels 8 bits.
- `clk_i` in 1: system clock.
- `rst_n_i` in 1: asynchronous active-low reset.
- `en_i` in 1: core enable; low synchronously clears the pipeline.
- `pclk_en_i` in 1: pixel-clock enable; all pipeline state advances only when `en_i && pclk_en_i`.
- `mode_i` in 2: pixel format. `00` RGB332 (4 px/word), `01` RGB565 (2 px/word), `10`/`11` RGB888 (1 px/word).
- `hpol_i`, `vpol_i` in 1: sync polarity; 1 inverts the corresponding output sync.
- `clr_i` in 1: single-cycle pulse; clears `underflow_o` and `urun_cnt_o`.
- `de_i`, `hsync_i`, `vsync_i`, `hend_i`, `vend_i` in 1 each: strobes from the timing generator.
- `fifo_valid_i` in 1: FIFO not empty.
- `fifo_data_i` in 32: FIFO head word.
- `fifo_ready_o` out 1: pop strobe, combinational.
- `red_o`, `green_o`, `blue_o` out 8 each: pixel colour.
- `hsync_o`, `vsync_o`, `de_o` out 1 each: aligned video controls.
- `vend_o` out 1: delayed frame-end pulse, one enabled step wide.
- `underflow_o` out 1: sticky underrun flag.
- `urun_cnt_o` out 16: saturating count of underrun words.

## Operation
- Step: a clock cycle with `en_i && pclk_en_i`. All pipeline registers are held on non-step cycles.
- Mode register `mode_q`:
  - Loads `mode_i` when `en_i` is low, or on a step with `vend_i`.
  - Reset value `2'b10`.
  - It never changes mid-frame.
- Sub-pixel index `idx`, width 2:
  - RGB332 counts 0..3, RGB565 counts 0..1, RGB888 stays at 0.
  - Advances on steps with `de_i`.
  - Wraps to 0 after the last pixel of a word.
  - A step with `hend_i` forces `idx` to 0, so every line starts word-aligned and any unused pixels of the last word are dropped.
  - Reset value 0.
- Pop rule: `fifo_ready_o = en_i && pclk_en_i && de_i && idx==0 && fifo_valid_i`.
  - The popped word is stored in `word_q`; pixel 0 is taken directly from `fifo_data_i`.
  - Later pixels come from `word_q`.
  - Pixel n occupies the least-significant-first slot: bits `[8n+7:8n]` for RGB332, `[16n+15:16n]` for RGB565, `[23:0]` for RGB888. Bits `[31:24]` are ignored in RGB888.
- Underrun:
  - Condition: a step with `de_i && idx==0 && !fifo_valid_i`.
  - No pop occurs.
  - `bad_q` is set, and every pixel of that word slot (until `idx` next returns to 0) outputs black.
  - `underflow_o` is set.
  - `urun_cnt_o` increments once, saturating at `16'hFFFF`.
- Expansion to RGB888 (MSB replication):
  - RGB332: `R={r3,r3,r3[2:1]}`, `G={g3,g3,g3[2:1]}`, `B={b2,b2,b2,b2}`.
  - RGB565: `R={r5,r5[4:2]}`, `G={g6,g6[5:4]}`, `B={b5,b5[4:2]}`.
  - Packing: RGB332 uses `[7:5]=R`, `[4:2]=G`, `[1:0]=B`. RGB565 uses `[15:11]=R`, `[10:5]=G`, `[4:0]=B`. RGB888 uses `[23:16]=R`, `[15:8]=G`, `[7:0]=B`.
- Blanking: when the delayed DE is 0, the colour outputs are 0.
- Sync outputs: `hsync_o = delayed hsync_i ^ hpol_i`, `vsync_o = delayed vsync_i ^ vpol_i`. Polarity is applied before the output register.
- `en_i` low:
  - `fifo_ready_o = 0`.
  - Clears `idx`, `bad_q` and both pipeline stages to 0 on the next clock.
  - `underflow_o` and `urun_cnt_o` hold.
- Simultaneous `clr_i` and underrun: the underrun wins. The flag stays 1 and the count becomes 1.

## Timing
- Pipeline depth: 2 steps.
  - Stage 1 registers the raw pixel, `bad`, DE, syncs and vend.
  - Stage 2 registers the expanded colour and the output controls.
- Input alignment: inputs sampled at step k appear on the outputs after the clock edge of step k+1.
- Control alignment: `de_o`, `hsync_o`, `vsync_o` and `vend_o` use the same 2-step delay as the colour, so they stay aligned.
- Reset values: all outputs are 0, `underflow_o` is 0 and `urun_cnt_o` is 0. `mode_q` resets to `2'b10`.
- Clear timing: `clr_i` takes effect on the next clock edge, independent of `pclk_en_i`.

## Test plan
- RGB888 sweep:
  - Stimulus: 4 visible pixels, FIFO words `0x00112233`, `0x00445566`, … with `pclk_en_i=1`.
  - Response: `fifo_ready_o` high for 4 steps; RGB `11/22/33` appears 2 steps after the first `de_i`, aligned with `de_o`.
- RGB565 unpack:
  - Stimulus: word `0xF800001F`.
  - Response: pixel 0 is `00/00/FF`, pixel 1 is `FF/00/00`; exactly one pop per 2 pixels.
- RGB332 with a line of 6 pixels:
  - Response: 2 pops; after `hend_i`, pixels 6–7 of the second word are dropped and the next line pops a fresh word.
  - Word `0x000000E3` expands pixel 0 to `FF/00/FF`.
- Underrun:
  - Stimulus: `fifo_valid_i=0` at `idx==0` in RGB565.
  - Response: two black pixels, `underflow_o=1`, `urun_cnt_o=1`, no pop; `clr_i` returns the count to 0.
- Polarity and pclk gating:
  - Stimulus: `hpol_i=1`, `pclk_en_i` high every 4th cycle.
  - Response: `hsync_o` is inverted and outputs change only after enabled cycles.
- Mid-frame control:
  - Stimulus: `mode_i` changed mid-frame, then `en_i` dropped mid-line.
  - Response: the mode applies only after `vend_i`; with `en_i` low, outputs clear to 0 next clock and no pops occur.
